// File: rtl/ball_pkg.sv
// Shared types and screen limits for the ball block and its observers.
package ball_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned EDGE_W  = 11;

  localparam int unsigned SCR_X_MIN = 0;
  localparam int unsigned SCR_X_MAX = 639;
  localparam int unsigned SCR_Y_MIN = 0;
  localparam int unsigned SCR_Y_MAX = 479;

  localparam int unsigned DEF_MAX_STEP     = 4;
  localparam int unsigned DEF_STALL_FRAMES = 60;
  localparam int unsigned DEF_CNT_W        = 16;

  typedef enum logic [1:0] {
    DIR_UNK   = 2'd0,
    DIR_STILL = 2'd1,
    DIR_POS   = 2'd2,
    DIR_NEG   = 2'd3
  } dir_t;

  // Magnitude of a signed 10-bit delta; -512 maps to 512, which still fits unsigned.
  function automatic logic [COORD_W-1:0] abs10(input logic [COORD_W-1:0] v);
    logic [COORD_W-1:0] neg;
    neg   = (~v) + COORD_W'(1);
    abs10 = v[COORD_W-1] ? neg : v;
  endfunction

endpackage

// File: rtl/axis_tracker.sv
// One axis of the ball motion monitor: previous sample, delta, jump check,
// direction FSM with bounce pulse, and limit-contact flag.
module axis_tracker
  import ball_pkg::*;
#(
  parameter int unsigned MIN      = SCR_X_MIN,
  parameter int unsigned MAX      = SCR_X_MAX,
  parameter int unsigned MAX_STEP = DEF_MAX_STEP
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               arm_i,
  input  logic [COORD_W-1:0] pos_i,
  input  logic [COORD_W-1:0] size_i,
  output logic [COORD_W-1:0] delta_o,
  output dir_t               dir_o,
  output logic               bounce_o,
  output logic               edge_o,
  output logic               jump_c_o,
  output logic               still_c_o
);

  logic [COORD_W-1:0] prev_q;
  logic [COORD_W-1:0] delta_q;
  logic [COORD_W-1:0] delta_d;
  logic [COORD_W-1:0] mag;
  dir_t               dir_q;
  dir_t               dir_d;
  logic               bounce_q;
  logic               edge_q;
  logic               edge_d;
  logic [EDGE_W-1:0]  far_sum;
  logic [EDGE_W-1:0]  near_lim;

  // Raw delta (mod 2^10), its magnitude, and the direction it points to.
  always_comb begin
    delta_d   = pos_i - prev_q;
    mag       = abs10(delta_d);
    jump_c_o  = arm_i && (mag > COORD_W'(MAX_STEP));
    still_c_o = (delta_d == '0);
    dir_d     = DIR_STILL;
    if (delta_d != '0) begin
      dir_d = delta_d[COORD_W-1] ? DIR_NEG : DIR_POS;
    end
  end

  // Limit contact at 11 bits so neither sum can wrap.
  always_comb begin
    far_sum  = EDGE_W'(pos_i) + EDGE_W'(size_i);
    near_lim = EDGE_W'(MIN) + EDGE_W'(size_i);
    edge_d   = (far_sum >= EDGE_W'(MAX)) || (EDGE_W'(pos_i) <= near_lim);
  end

  // Direction FSM plus prev/delta/edge registers; a jump frame freezes the FSM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q   <= '0;
      delta_q  <= '0;
      dir_q    <= DIR_UNK;
      bounce_q <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      prev_q   <= pos_i;
      edge_q   <= edge_d;
      bounce_q <= 1'b0;
      if (arm_i) begin
        delta_q <= delta_d;
        if (!jump_c_o) begin
          dir_q <= dir_d;
          case (dir_q)
            DIR_POS: bounce_q <= (dir_d == DIR_NEG);
            DIR_NEG: bounce_q <= (dir_d == DIR_POS);
            default: bounce_q <= 1'b0;
          endcase
        end
      end
    end
  end

  assign delta_o  = delta_q;
  assign dir_o    = dir_q;
  assign bounce_o = bounce_q;
  assign edge_o   = edge_q;

endmodule

// File: rtl/ball_motion_monitor.sv
// Frame-rate observer of the ball position bus: deltas, directions,
// bounces, edge contact, stall and illegal-jump detection.
module ball_motion_monitor
  import ball_pkg::*;
#(
  parameter int unsigned X_MIN        = SCR_X_MIN,
  parameter int unsigned X_MAX        = SCR_X_MAX,
  parameter int unsigned Y_MIN        = SCR_Y_MIN,
  parameter int unsigned Y_MAX        = SCR_Y_MAX,
  parameter int unsigned MAX_STEP     = DEF_MAX_STEP,
  parameter int unsigned STALL_FRAMES = DEF_STALL_FRAMES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic [COORD_W-1:0] BallX,
  input  logic [COORD_W-1:0] BallY,
  input  logic [COORD_W-1:0] BallS,
  output logic [COORD_W-1:0] dx,
  output logic [COORD_W-1:0] dy,
  output dir_t               dir_x,
  output dir_t               dir_y,
  output logic               bounce_x,
  output logic               bounce_y,
  output logic [CNT_W-1:0]   bounce_count,
  output logic               edge_x,
  output logic               edge_y,
  output logic               stall,
  output logic               jump_err,
  output logic               valid
);

  localparam int unsigned STALL_W = $clog2(STALL_FRAMES + 1);
  localparam int unsigned SUM_W   = CNT_W + 1;

  logic               armed_q;
  logic               valid_q;
  logic               jump_err_q;
  logic               jump_x_c;
  logic               jump_y_c;
  logic               still_x_c;
  logic               still_y_c;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [SUM_W-1:0]   cnt_sum;
  logic [STALL_W-1:0] stall_cnt_q;
  logic [STALL_W-1:0] stall_cnt_d;
  logic               stall_q;

  axis_tracker #(
    .MIN      (X_MIN),
    .MAX      (X_MAX),
    .MAX_STEP (MAX_STEP)
  ) u_axis_x (
    .clk_i     (frame_clk),
    .rst_i     (Reset),
    .arm_i     (armed_q),
    .pos_i     (BallX),
    .size_i    (BallS),
    .delta_o   (dx),
    .dir_o     (dir_x),
    .bounce_o  (bounce_x),
    .edge_o    (edge_x),
    .jump_c_o  (jump_x_c),
    .still_c_o (still_x_c)
  );

  axis_tracker #(
    .MIN      (Y_MIN),
    .MAX      (Y_MAX),
    .MAX_STEP (MAX_STEP)
  ) u_axis_y (
    .clk_i     (frame_clk),
    .rst_i     (Reset),
    .arm_i     (armed_q),
    .pos_i     (BallY),
    .size_i    (BallS),
    .delta_o   (dy),
    .dir_o     (dir_y),
    .bounce_o  (bounce_y),
    .edge_o    (edge_y),
    .jump_c_o  (jump_y_c),
    .still_c_o (still_y_c)
  );

  // Saturating reversal total; a double reversal adds two at once.
  always_comb begin
    cnt_sum = SUM_W'(cnt_q) + SUM_W'(bounce_x) + SUM_W'(bounce_y);
    cnt_d   = cnt_sum[SUM_W-1] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  // Zero-motion frame counter, saturating, cleared by any movement.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_q) begin
      if (still_x_c && still_y_c) begin
        if (stall_cnt_q != STALL_W'(STALL_FRAMES)) begin
          stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
      end else begin
        stall_cnt_d = '0;
      end
    end
  end

  // First edge only arms the trackers; valid follows one frame later.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      armed_q     <= 1'b0;
      valid_q     <= 1'b0;
      jump_err_q  <= 1'b0;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      armed_q     <= 1'b1;
      valid_q     <= armed_q;
      jump_err_q  <= jump_err_q | jump_x_c | jump_y_c;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= (stall_cnt_d == STALL_W'(STALL_FRAMES));
    end
  end

  assign valid        = valid_q;
  assign jump_err     = jump_err_q;
  assign bounce_count = cnt_q;
  assign stall        = stall_q;

endmodule

// File: tb/tb_ball_motion_monitor.sv
// Directed bench for ball_motion_monitor: a default instance plus a
// 4-bit-counter instance for the saturation scenario.
module tb_ball_motion_monitor;

  localparam logic [1:0] D_UNK   = 2'd0;
  localparam logic [1:0] D_STILL = 2'd1;
  localparam logic [1:0] D_POS   = 2'd2;
  localparam logic [1:0] D_NEG   = 2'd3;

  logic        frame_clk;
  logic        Reset;
  logic [9:0]  bx, by, bs;
  logic [9:0]  dx, dy;
  logic [1:0]  dir_x, dir_y;
  logic        bounce_x, bounce_y, edge_x, edge_y, stall, jump_err, valid;
  logic [15:0] bounce_count;

  logic [9:0]  bx4, by4, bs4;
  logic [9:0]  dx4, dy4;
  logic [1:0]  dir_x4, dir_y4;
  logic        bounce_x4, bounce_y4, edge_x4, edge_y4, stall4, jump_err4, valid4;
  logic [3:0]  bounce_count4;

  int total = 0;
  int bad   = 0;

  ball_motion_monitor u_dut (
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .BallX        (bx),
    .BallY        (by),
    .BallS        (bs),
    .dx           (dx),
    .dy           (dy),
    .dir_x        (dir_x),
    .dir_y        (dir_y),
    .bounce_x     (bounce_x),
    .bounce_y     (bounce_y),
    .bounce_count (bounce_count),
    .edge_x       (edge_x),
    .edge_y       (edge_y),
    .stall        (stall),
    .jump_err     (jump_err),
    .valid        (valid)
  );

  ball_motion_monitor #(.CNT_W(4)) u_dut4 (
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .BallX        (bx4),
    .BallY        (by4),
    .BallS        (bs4),
    .dx           (dx4),
    .dy           (dy4),
    .dir_x        (dir_x4),
    .dir_y        (dir_y4),
    .bounce_x     (bounce_x4),
    .bounce_y     (bounce_y4),
    .bounce_count (bounce_count4),
    .edge_x       (edge_x4),
    .edge_y       (edge_y4),
    .stall        (stall4),
    .jump_err     (jump_err4),
    .valid        (valid4)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  // Pulse reset between edges; the next posedge is the first edge after reset.
  task automatic do_reset();
    #1;
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bx = 10'd320; by = 10'd240; bs = 10'd4;
    bx4 = 10'd100; by4 = 10'd100; bs4 = 10'd4;
    repeat (2) @(negedge frame_clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0d exp=0", valid); end
    total++; if (dx !== 10'd0) begin bad++; $display("FAIL rst_dx got=%0d exp=0", dx); end
    total++; if (dir_x !== D_UNK || dir_y !== D_UNK) begin bad++; $display("FAIL rst_dir got=%0d/%0d exp=0/0", dir_x, dir_y); end
    total++; if (bounce_count !== 16'd0 || stall !== 1'b0 || jump_err !== 1'b0) begin
      bad++; $display("FAIL rst_misc cnt=%0d stall=%0d jump=%0d exp=0/0/0", bounce_count, stall, jump_err); end
    total++; if (edge_x !== 1'b0 || edge_y !== 1'b0) begin bad++; $display("FAIL rst_edge got=%0d/%0d exp=0/0", edge_x, edge_y); end
    Reset = 1'b0;
  endtask

  task automatic test_stall();
    tick(); // edge 1
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL e1_valid got=%0d exp=0", valid); end
    tick(); // edge 2
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL e2_valid got=%0d exp=1", valid); end
    total++; if (dx !== 10'd0) begin bad++; $display("FAIL e2_dx got=%0d exp=0", dx); end
    total++; if (dir_x !== D_STILL) begin bad++; $display("FAIL e2_dir_x got=%0d exp=%0d", dir_x, D_STILL); end
    repeat (59) tick(); // edge 61
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_early got=%0d exp=0", stall); end
    tick(); // edge 62
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_set got=%0d exp=1", stall); end
    tick();
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_hold got=%0d exp=1", stall); end
    bx = 10'd321;
    tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_drop got=%0d exp=0", stall); end
    total++; if (dx !== 10'd1 || dir_x !== D_POS) begin bad++; $display("FAIL step_dx got=%0d/%0d exp=1/%0d", dx, dir_x, D_POS); end
  endtask

  task automatic test_bounce();
    bx = 10'd320; by = 10'd240; bs = 10'd4;
    do_reset();
    tick();                     // captures 320
    bx = 10'd321; tick();
    total++; if (dir_x !== D_POS || bounce_x !== 1'b0) begin bad++; $display("FAIL b_e2 dir=%0d bnc=%0d exp=%0d/0", dir_x, bounce_x, D_POS); end
    bx = 10'd322; tick();
    total++; if (dir_x !== D_POS || bounce_x !== 1'b0) begin bad++; $display("FAIL b_e3 dir=%0d bnc=%0d exp=%0d/0", dir_x, bounce_x, D_POS); end
    bx = 10'd321; tick();
    total++; if (dir_x !== D_NEG || bounce_x !== 1'b1) begin bad++; $display("FAIL b_e4 dir=%0d bnc=%0d exp=%0d/1", dir_x, bounce_x, D_NEG); end
    total++; if (dx !== 10'h3FF) begin bad++; $display("FAIL b_e4_dx got=%h exp=3ff", dx); end
    tick();
    total++; if (bounce_x !== 1'b0) begin bad++; $display("FAIL b_pulse_len got=%0d exp=0", bounce_x); end
    total++; if (bounce_count !== 16'd1) begin bad++; $display("FAIL b_count got=%0d exp=1", bounce_count); end
    total++; if (bounce_y !== 1'b0) begin bad++; $display("FAIL b_y got=%0d exp=0", bounce_y); end
  endtask

  task automatic test_still_reversal();
    logic seen;
    seen = 1'b0;
    bx = 10'd100;
    do_reset();
    tick();
    bx = 10'd101; tick(); seen |= bounce_x;
    total++; if (dir_x !== D_POS) begin bad++; $display("FAIL s_pos got=%0d exp=%0d", dir_x, D_POS); end
    tick(); seen |= bounce_x;
    total++; if (dir_x !== D_STILL) begin bad++; $display("FAIL s_still got=%0d exp=%0d", dir_x, D_STILL); end
    bx = 10'd100; tick(); seen |= bounce_x;
    total++; if (dir_x !== D_NEG) begin bad++; $display("FAIL s_neg got=%0d exp=%0d", dir_x, D_NEG); end
    tick(); seen |= bounce_x;
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL s_no_bounce got=%0d exp=0", seen); end
    total++; if (bounce_count !== 16'd0) begin bad++; $display("FAIL s_count got=%0d exp=0", bounce_count); end
  endtask

  task automatic test_edges();
    bx = 10'd635; by = 10'd475; bs = 10'd4;
    do_reset();
    tick();
    total++; if (edge_x !== 1'b1) begin bad++; $display("FAIL edge_right got=%0d exp=1", edge_x); end
    total++; if (edge_y !== 1'b1) begin bad++; $display("FAIL edge_bottom got=%0d exp=1", edge_y); end
    bx = 10'd4; tick();
    total++; if (edge_x !== 1'b1) begin bad++; $display("FAIL edge_left got=%0d exp=1", edge_x); end
    bx = 10'd5; by = 10'd240; tick();
    total++; if (edge_x !== 1'b0) begin bad++; $display("FAIL edge_clear_x got=%0d exp=0", edge_x); end
    total++; if (edge_y !== 1'b0) begin bad++; $display("FAIL edge_clear_y got=%0d exp=0", edge_y); end
  endtask

  task automatic test_jump();
    bx = 10'd318; by = 10'd240; bs = 10'd4;
    do_reset();
    tick();
    bx = 10'd319; tick();
    bx = 10'd320; tick();
    total++; if (jump_err !== 1'b0) begin bad++; $display("FAIL j_pre got=%0d exp=0", jump_err); end
    bx = 10'd330; tick();
    total++; if (dx !== 10'd10) begin bad++; $display("FAIL j_dx got=%0d exp=10", dx); end
    total++; if (jump_err !== 1'b1) begin bad++; $display("FAIL j_err got=%0d exp=1", jump_err); end
    total++; if (dir_x !== D_POS || bounce_x !== 1'b0) begin bad++; $display("FAIL j_hold dir=%0d bnc=%0d exp=%0d/0", dir_x, bounce_x, D_POS); end
    bx = 10'd331; tick();
    total++; if (jump_err !== 1'b1 || dx !== 10'd1) begin bad++; $display("FAIL j_sticky err=%0d dx=%0d exp=1/1", jump_err, dx); end
    #2;
    Reset = 1'b1;
    #1;
    total++; if (jump_err !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL j_async err=%0d valid=%0d exp=0/0", jump_err, valid); end
    total++; if (dx !== 10'd0 || dir_x !== D_UNK || edge_x !== 1'b0) begin
      bad++; $display("FAIL j_async_out dx=%0d dir=%0d edge=%0d exp=0/0/0", dx, dir_x, edge_x); end
    #2;
    Reset = 1'b0;
  endtask

  task automatic test_saturate();
    int xs[15] = '{100, 101, 100, 101, 100, 101, 100, 101, 100, 101, 101, 102, 101, 102, 102};
    int ys[15] = '{100, 100, 100, 101, 100, 101, 100, 101, 100, 100, 101, 102, 101, 102, 102};
    bx4 = 10'd100; by4 = 10'd100; bs4 = 10'd4;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bx4 = 10'(xs[i]);
      by4 = 10'(ys[i]);
      tick();
      if (i == 9) begin
        total++; if (bounce_count4 !== 4'd12) begin bad++; $display("FAIL sat_12 got=%0d exp=12", bounce_count4); end
      end
      if (i == 10) begin
        total++; if (bounce_count4 !== 4'd13) begin bad++; $display("FAIL sat_13 got=%0d exp=13", bounce_count4); end
      end
      if (i == 12) begin
        total++; if (bounce_x4 !== 1'b1 || bounce_y4 !== 1'b1) begin bad++; $display("FAIL sat_dual got=%0d/%0d exp=1/1", bounce_x4, bounce_y4); end
      end
      if (i == 13) begin
        total++; if (bounce_count4 !== 4'd15) begin bad++; $display("FAIL sat_15 got=%0d exp=15", bounce_count4); end
      end
      if (i == 14) begin
        total++; if (bounce_count4 !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", bounce_count4); end
      end
    end
    total++; if (jump_err4 !== 1'b0) begin bad++; $display("FAIL sat_jump got=%0d exp=0", jump_err4); end
    // Wrap 0 -> 1023 is a step of -1, not a jump.
    bx4 = 10'd0; by4 = 10'd100;
    do_reset();
    tick();
    bx4 = 10'd1023; tick();
    total++; if (dx4 !== 10'h3FF) begin bad++; $display("FAIL wrap_dx got=%h exp=3ff", dx4); end
    total++; if (jump_err4 !== 1'b0 || dir_x4 !== D_NEG) begin bad++; $display("FAIL wrap_dir err=%0d dir=%0d exp=0/%0d", jump_err4, dir_x4, D_NEG); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_bounce();
    test_still_reversal();
    test_edges();
    test_jump();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
